// File: rtl/nmi_sched_pkg.sv
// Shared types and constants for the NMI scheduler: FSM states, CPU bus payload, Z80 opcodes.
package nmi_sched_pkg;

    typedef enum logic [2:0] {
        NMI_IDLE,
        NMI_WAIT_INT,
        NMI_ASSERT,
        NMI_SERVICE,
        NMI_COOLDOWN
    } nmi_state_t;

    typedef struct packed {
        logic        mreq;
        logic        m1;
        logic        rd;
        logic [15:0] a;
        logic [7:0]  d;
    } cpu_bus_t;

    localparam logic [15:0] NMI_VECTOR = 16'h0066;
    localparam logic [7:0]  OP_ED      = 8'hED;
    localparam logic [7:0]  OP_RETN2   = 8'h45;

endpackage

// File: rtl/nmi_req_latch.sv
// Edge-detects NMI requests into sticky pending bits and picks the lowest pending index as winner.
module nmi_req_latch #(
    parameter  int unsigned NREQ  = 3,
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk28,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req_i,
    input  logic [NREQ-1:0]  clr_i,
    output logic [IDX_W-1:0] winner_c_o,
    output logic             any_c_o
);

    logic [NREQ-1:0] req_q;
    logic [NREQ-1:0] pending_q;
    logic [NREQ-1:0] pending_d;

    // A fresh edge wins over a same-cycle clear so that request is not lost.
    always_comb begin
        pending_d = (pending_q & ~clr_i) | (req_i & ~req_q);
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            pending_q <= '0;
        end else begin
            req_q     <= req_i;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        winner_c_o = '0;
        any_c_o    = |pending_q;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                winner_c_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/nmi_sched.sv
// Arbitrates NMI sources onto the single Z80 /NMI line, aligned to the ULA /INT edge,
// tracks ownership until RETN or a done pulse, then enforces a cooldown.
module nmi_sched
    import nmi_sched_pkg::*;
#(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned TIMEOUT  = 560000,
    parameter int unsigned COOLDOWN = 2800
) (
    input  logic            clk28,
    input  logic            rst_n,
    input  cpu_bus_t        bus_i,
    input  logic            n_int_i,
    input  logic            n_int_next_i,
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] done_i,
    output logic            n_nmi_o,
    output logic [NREQ-1:0] grant_o,
    output logic            nmi_active_o,
    output logic            timeout_err_o
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT);
    localparam int unsigned CD_W  = $clog2(COOLDOWN);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [CD_W-1:0]  CD_LAST  = CD_W'(COOLDOWN - 1);

    nmi_state_t       state_q,     state_d;
    logic             n_nmi_q,     n_nmi_d;
    logic [NREQ-1:0]  grant_q,     grant_d;
    logic             active_q,    active_d;
    logic             tmo_err_q,   tmo_err_d;
    logic [IDX_W-1:0] winner_q,    winner_d;
    logic [TMO_W-1:0] tmo_cnt_q,   tmo_cnt_d;
    logic [CD_W-1:0]  cd_cnt_q,    cd_cnt_d;
    logic [7:0]       op_q,        op_d;
    logic             m1_seen_q,   m1_seen_d;
    logic             seen_ed_q,   seen_ed_d;

    logic [NREQ-1:0]  clr_c;
    logic [IDX_W-1:0] winner_c;
    logic             any_c;
    logic             int_edge_c;
    logic             vec_fetch_c;
    logic             m1_rd_c;
    logic             release_c;

    nmi_req_latch #(.NREQ(NREQ)) u_req_latch (
        .clk28      (clk28),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .clr_i      (clr_c),
        .winner_c_o (winner_c),
        .any_c_o    (any_c)
    );

    assign int_edge_c  = n_int_i & ~n_int_next_i;
    assign vec_fetch_c = bus_i.m1 & bus_i.mreq & (bus_i.a == NMI_VECTOR);
    assign m1_rd_c     = bus_i.mreq & bus_i.m1 & bus_i.rd;

    always_comb begin
        state_d    = state_q;
        n_nmi_d    = n_nmi_q;
        grant_d    = grant_q;
        tmo_err_d  = tmo_err_q;
        winner_d   = winner_q;
        tmo_cnt_d  = tmo_cnt_q;
        cd_cnt_d   = cd_cnt_q;
        op_d       = op_q;
        m1_seen_d  = m1_seen_q;
        seen_ed_d  = seen_ed_q;
        clr_c      = '0;
        release_c  = 1'b0;

        case (state_q)
            NMI_IDLE: begin
                if (any_c) begin
                    winner_d = winner_c;
                    state_d  = NMI_WAIT_INT;
                end
            end
            NMI_WAIT_INT: begin
                if (int_edge_c) begin
                    n_nmi_d   = 1'b0;
                    grant_d   = NREQ'(1) << winner_q;
                    clr_c     = NREQ'(1) << winner_q;
                    tmo_cnt_d = '0;
                    state_d   = NMI_ASSERT;
                end
            end
            NMI_ASSERT: begin
                // The vector fetch takes precedence over a coincident expiry.
                if (vec_fetch_c) begin
                    n_nmi_d   = 1'b1;
                    tmo_err_d = 1'b0;
                    m1_seen_d = 1'b0;
                    seen_ed_d = 1'b0;
                    state_d   = NMI_SERVICE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    n_nmi_d   = 1'b1;
                    grant_d   = '0;
                    tmo_err_d = 1'b1;
                    cd_cnt_d  = '0;
                    state_d   = NMI_COOLDOWN;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            NMI_SERVICE: begin
                // Latch the opcode during the M1 read, judge it once MREQ drops.
                if (m1_rd_c) begin
                    op_d      = bus_i.d;
                    m1_seen_d = 1'b1;
                end else if (m1_seen_q && !bus_i.mreq) begin
                    m1_seen_d = 1'b0;
                    seen_ed_d = (op_q == OP_ED);
                    release_c = seen_ed_q && (op_q == OP_RETN2);
                end
                if (|(done_i & grant_q)) begin
                    release_c = 1'b1;
                end
                if (release_c) begin
                    grant_d   = '0;
                    cd_cnt_d  = '0;
                    m1_seen_d = 1'b0;
                    seen_ed_d = 1'b0;
                    state_d   = NMI_COOLDOWN;
                end
            end
            NMI_COOLDOWN: begin
                if (cd_cnt_q == CD_LAST) begin
                    state_d = NMI_IDLE;
                end else begin
                    cd_cnt_d = cd_cnt_q + CD_W'(1);
                end
            end
            default: begin
                state_d = NMI_IDLE;
            end
        endcase

        active_d = (state_d == NMI_ASSERT) || (state_d == NMI_SERVICE);
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= NMI_IDLE;
            n_nmi_q   <= 1'b1;
            grant_q   <= '0;
            active_q  <= 1'b0;
            tmo_err_q <= 1'b0;
            winner_q  <= '0;
            tmo_cnt_q <= '0;
            cd_cnt_q  <= '0;
            op_q      <= '0;
            m1_seen_q <= 1'b0;
            seen_ed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_nmi_q   <= n_nmi_d;
            grant_q   <= grant_d;
            active_q  <= active_d;
            tmo_err_q <= tmo_err_d;
            winner_q  <= winner_d;
            tmo_cnt_q <= tmo_cnt_d;
            cd_cnt_q  <= cd_cnt_d;
            op_q      <= op_d;
            m1_seen_q <= m1_seen_d;
            seen_ed_q <= seen_ed_d;
        end
    end

    assign n_nmi_o       = n_nmi_q;
    assign grant_o       = grant_q;
    assign nmi_active_o  = active_q;
    assign timeout_err_o = tmo_err_q;

endmodule

// File: tb/tb_nmi_sched.sv
// Self-checking bench for nmi_sched: directed scenarios plus a randomized request/service loop.
module tb_nmi_sched;
    import nmi_sched_pkg::*;

    localparam int unsigned NREQ = 3;
    localparam int unsigned TMO  = 1000;
    localparam int unsigned CD   = 2800;

    logic            clk28;
    logic            rst_n;
    cpu_bus_t        bus;
    logic            n_int;
    logic            n_int_next;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] done;
    logic            n_nmi;
    logic [NREQ-1:0] grant;
    logic            nmi_active;
    logic            timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NREQ-1:0] mdl_pend;
    logic            snap_nmi;
    logic [NREQ-1:0] snap_grant;
    logic            snap_active;
    logic            nmi_after_c1;

    nmi_sched #(.NREQ(NREQ), .TIMEOUT(TMO), .COOLDOWN(CD)) dut (
        .clk28         (clk28),
        .rst_n         (rst_n),
        .bus_i         (bus),
        .n_int_i       (n_int),
        .n_int_next_i  (n_int_next),
        .req_i         (req),
        .done_i        (done),
        .n_nmi_o       (n_nmi),
        .grant_o       (grant),
        .nmi_active_o  (nmi_active),
        .timeout_err_o (timeout_err)
    );

    initial clk28 = 1'b0;
    always #5 clk28 = ~clk28;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk28);
            #1;
        end
    endtask

    function automatic logic [NREQ-1:0] lowest(input logic [NREQ-1:0] m);
        return m & (~m + NREQ'(1));
    endfunction

    task automatic int_idle();
        n_int = 1'b1; n_int_next = 1'b1;
    endtask

    task automatic int_hold_edge();
        n_int = 1'b1; n_int_next = 1'b0;
    endtask

    // One-cycle /INT falling edge; snapshot outputs right after that edge.
    task automatic int_pulse();
        int_hold_edge();
        cyc(1);
        snap_nmi = n_nmi; snap_grant = grant; snap_active = nmi_active;
        int_idle();
    endtask

    task automatic pulse_req(input logic [NREQ-1:0] m);
        req = m;
        cyc(1);
        req = '0;
        cyc(1);
        mdl_pend = mdl_pend | m;
    endtask

    // Two-cycle M1 read, then one cycle with MREQ low.
    task automatic fetch(input logic [15:0] a, input logic [7:0] d);
        bus.m1 = 1'b1; bus.mreq = 1'b1; bus.rd = 1'b1; bus.a = a; bus.d = d;
        cyc(1);
        nmi_after_c1 = n_nmi;
        cyc(1);
        bus = '0;
        cyc(1);
    endtask

    task automatic pulse_done(input logic [NREQ-1:0] m);
        done = m;
        cyc(1);
        done = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req = '0; done = '0; bus = '0; int_idle();
        mdl_pend = '0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (n_nmi !== 1'b1) begin n_fail++; $display("FAIL reset_nmi: got %b want 1", n_nmi); end
        n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b want 000", grant); end
        n_checks++; if (nmi_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", nmi_active); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
    endtask

    task automatic test_int_align();
        apply_reset();
        pulse_req(3'b010);
        cyc(3000);
        n_checks++; if (n_nmi !== 1'b1 || grant !== 3'b000) begin n_fail++; $display("FAIL t1_before_int: got nmi=%b grant=%b want nmi=1 grant=000", n_nmi, grant); end
        int_pulse();
        n_checks++; if (snap_nmi !== 1'b0) begin n_fail++; $display("FAIL t1_nmi_low: got %b want 0", snap_nmi); end
        n_checks++; if (snap_grant !== 3'b010) begin n_fail++; $display("FAIL t1_grant: got %b want 010", snap_grant); end
        n_checks++; if (snap_active !== 1'b1) begin n_fail++; $display("FAIL t1_active: got %b want 1", snap_active); end
        fetch(NMI_VECTOR, 8'h00);
        n_checks++; if (nmi_after_c1 !== 1'b1) begin n_fail++; $display("FAIL t1_nmi_release: got %b want 1", nmi_after_c1); end
        n_checks++; if (grant !== 3'b010) begin n_fail++; $display("FAIL t1_grant_service: got %b want 010", grant); end
    endtask

    task automatic test_retn();
        logic [7:0] ops[5] = '{8'hED, 8'h00, 8'h45, 8'hED, 8'h45};
        apply_reset();
        pulse_req(3'b010);
        cyc(5);
        int_pulse();
        fetch(NMI_VECTOR, 8'h00);
        pulse_req(3'b001);
        for (int k = 0; k < 5; k++) begin
            fetch(16'h1000 + 16'(k), ops[k]);
            if (k < 4) begin
                n_checks++; if (grant !== 3'b010) begin n_fail++; $display("FAIL t2_no_release_%0d: got %b want 010", k, grant); end
            end
        end
        n_checks++; if (grant !== 3'b000 || nmi_active !== 1'b0) begin n_fail++; $display("FAIL t2_retn: got grant=%b act=%b want 000/0", grant, nmi_active); end
        int_hold_edge();
        cyc(CD + 1);
        n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL t2_cooldown_hold: got %b want 000", grant); end
        cyc(1);
        n_checks++; if (grant !== 3'b001 || n_nmi !== 1'b0) begin n_fail++; $display("FAIL t2_after_cooldown: got grant=%b nmi=%b want 001/0", grant, n_nmi); end
    endtask

    task automatic test_priority();
        apply_reset();
        pulse_req(3'b101);
        cyc(5);
        int_pulse();
        n_checks++; if (snap_grant !== 3'b001) begin n_fail++; $display("FAIL t3_first: got %b want 001", snap_grant); end
        fetch(NMI_VECTOR, 8'h00);
        pulse_done(3'b001);
        n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL t3_release: got %b want 000", grant); end
        int_hold_edge();
        cyc(CD + 1);
        n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL t3_cooldown_hold: got %b want 000", grant); end
        cyc(1);
        n_checks++; if (grant !== 3'b100) begin n_fail++; $display("FAIL t3_second: got %b want 100", grant); end
    endtask

    task automatic test_timeout();
        apply_reset();
        pulse_req(3'b100);
        cyc(5);
        int_pulse();
        cyc(TMO - 1);
        n_checks++; if (n_nmi !== 1'b0 || grant !== 3'b100) begin n_fail++; $display("FAIL t4_pre_expiry: got nmi=%b grant=%b want 0/100", n_nmi, grant); end
        cyc(1);
        n_checks++; if (n_nmi !== 1'b1 || timeout_err !== 1'b1 || grant !== 3'b000) begin n_fail++; $display("FAIL t4_expiry: got nmi=%b terr=%b grant=%b want 1/1/000", n_nmi, timeout_err, grant); end
        pulse_req(3'b010);
        int_hold_edge();
        cyc(CD - 1);
        n_checks++; if (grant !== 3'b000 || timeout_err !== 1'b1) begin n_fail++; $display("FAIL t4_cooldown: got grant=%b terr=%b want 000/1", grant, timeout_err); end
        cyc(1);
        n_checks++; if (grant !== 3'b010) begin n_fail++; $display("FAIL t4_regrant: got %b want 010", grant); end
        int_idle();
        fetch(NMI_VECTOR, 8'h00);
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL t4_terr_clear: got %b want 0", timeout_err); end
    endtask

    task automatic test_done();
        apply_reset();
        req = 3'b001;
        cyc(3);
        int_pulse();
        n_checks++; if (snap_grant !== 3'b001) begin n_fail++; $display("FAIL t5_grant: got %b want 001", snap_grant); end
        fetch(NMI_VECTOR, 8'h00);
        pulse_done(3'b100);
        n_checks++; if (grant !== 3'b001) begin n_fail++; $display("FAIL t5_foreign_done: got %b want 001", grant); end
        pulse_done(3'b001);
        n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL t5_owner_done: got %b want 000", grant); end
        int_hold_edge();
        cyc(CD + 10);
        n_checks++; if (grant !== 3'b000 || n_nmi !== 1'b1) begin n_fail++; $display("FAIL t5_level_no_retrigger: got grant=%b nmi=%b want 000/1", grant, n_nmi); end
        req = '0;
        int_idle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        pulse_req(3'b001);
        cyc(2);
        int_pulse();
        pulse_req(3'b010);
        rst_n = 1'b0;
        #2;
        n_checks++; if (n_nmi !== 1'b1 || grant !== 3'b000 || nmi_active !== 1'b0) begin n_fail++; $display("FAIL t6_async: got nmi=%b grant=%b act=%b want 1/000/0", n_nmi, grant, nmi_active); end
        cyc(2);
        rst_n = 1'b1;
        mdl_pend = '0;
        int_hold_edge();
        cyc(20);
        n_checks++; if (grant !== 3'b000 || n_nmi !== 1'b1) begin n_fail++; $display("FAIL t6_pending_lost: got grant=%b nmi=%b want 000/1", grant, n_nmi); end
        int_idle();
    endtask

    // Reference: the winner is frozen when the scheduler becomes free with something pending;
    // RETN releases when the opcode after an ED is 45.
    task automatic test_random();
        logic [NREQ-1:0] m, exp_w;
        logic [7:0]      b;
        logic            prev_ed, rel;
        apply_reset();
        for (int it = 0; it < 6; it++) begin
            m = NREQ'($urandom_range(1, 7));
            if (mdl_pend != '0) begin
                exp_w = lowest(mdl_pend);
                if ($urandom_range(0, 1) == 0) m = '0;
            end else begin
                exp_w = lowest(m);
            end
            if (m != '0) pulse_req(m);
            cyc(int'($urandom_range(2, 40)));
            mdl_pend = mdl_pend & ~exp_w;
            int_pulse();
            n_checks++; if (snap_grant !== exp_w || snap_nmi !== 1'b0) begin n_fail++; $display("FAIL rnd_grant_%0d: got grant=%b nmi=%b want %b/0", it, snap_grant, snap_nmi, exp_w); end
            fetch(NMI_VECTOR, 8'h00);
            prev_ed = 1'b0;
            rel = 1'b0;
            for (int k = 0; k < 10 && !rel; k++) begin
                case ($urandom_range(0, 3))
                    0: b = 8'hED;
                    1: b = 8'h45;
                    2: b = 8'h00;
                    default: b = 8'($urandom);
                endcase
                fetch(16'($urandom), b);
                rel = prev_ed && (b == 8'h45);
                prev_ed = (b == 8'hED);
                n_checks++; if (grant !== (rel ? 3'b000 : exp_w)) begin n_fail++; $display("FAIL rnd_op_%0d_%0d: got %b want %b (op %h)", it, k, grant, rel ? 3'b000 : exp_w, b); end
            end
            if (!rel) begin
                pulse_done(exp_w);
                n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL rnd_done_%0d: got %b want 000", it, grant); end
            end
            cyc(CD + 10);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; done = '0; bus = '0; mdl_pend = '0;
        n_int = 1'b1; n_int_next = 1'b1;
        test_reset();
        test_int_align();
        test_retn();
        test_priority();
        test_timeout();
        test_done();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
